// File: rtl/pdm_ddr_capture_ctrl.sv
// PDM bit-clock generator and DDR-to-SDR capture sequencer for a mic array.
// Splits each DDR line into a ch0/ch1 word pair per PDM period and hands it downstream.
module pdm_ddr_capture_ctrl #(
  parameter int N_LINES        = 8,
  parameter int CLK_DIV        = 2,
  parameter int SETTLE_PERIODS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_LINES-1:0] ddr_data,
  output logic               pdm_clk,
  output logic [N_LINES-1:0] sdr_data_0,
  output logic [N_LINES-1:0] sdr_data_1,
  output logic               sdr_valid,
  input  logic               sdr_ready,
  input  logic               ovf_clr,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, STOP} state_t;

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int SW = $clog2(SETTLE_PERIODS + 1);
  localparam logic [CW-1:0] CNT_HI_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF    = CW'(CLK_DIV);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_PERIODS - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_PERIODS);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [SW-1:0]      settle_cnt;
  logic               from_run;
  logic [N_LINES-1:0] ch0_hold;
  logic               wrap;
  logic               new_pair;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    wrap      = (state != IDLE) && (cnt == CNT_LAST);
    // A STOP that started in SETTLE must not emit its final period.
    new_pair  = wrap && ((state == RUN) || ((state == STOP) && from_run));
    unique case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE: begin
        if (!enable)                              state_nxt = STOP;
        else if (wrap && settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      RUN:     if (!enable) state_nxt = STOP;
      STOP:    if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state == IDLE || wrap) ? '0 : cnt + CW'(1);
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pdm_clk  <= 1'b0;
      from_run <= 1'b0;
      ch0_hold <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // Registered from next-state so the rising edge lines up with cnt==0.
      pdm_clk <= (state_nxt != IDLE) && (cnt_nxt < CNT_HALF);
      if (state != STOP) from_run <= (state == RUN);
      if (state != IDLE && cnt == CNT_HI_LAST) ch0_hold <= ddr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
    end else if (state == IDLE && state_nxt == SETTLE) begin
      settle_cnt <= '0;
    end else if (state == SETTLE && wrap && settle_cnt != SETTLE_MAX) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdr_data_0 <= '0;
      sdr_data_1 <= '0;
      sdr_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (new_pair) begin
        sdr_data_0 <= ch0_hold;
        sdr_data_1 <= ddr_data;
        sdr_valid  <= 1'b1;
      end else if (sdr_valid && sdr_ready) begin
        sdr_valid  <= 1'b0;
      end
      // A fresh overflow beats a simultaneous clear.
      if (new_pair && sdr_valid && !sdr_ready) overflow <= 1'b1;
      else if (ovf_clr)                        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_ddr_capture_ctrl.sv
// Self-checking bench for pdm_ddr_capture_ctrl: directed scenarios plus random traffic
// compared against a time-index reference model.
module tb_pdm_ddr_capture_ctrl;

  localparam int N   = 8;
  localparam int CD  = 2;
  localparam int SP  = 4;
  localparam int PER = 2 * CD;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] ddr_data;
  logic         pdm_clk;
  logic [N-1:0] sdr_data_0;
  logic [N-1:0] sdr_data_1;
  logic         sdr_valid;
  logic         sdr_ready;
  logic         ovf_clr;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;

  pdm_ddr_capture_ctrl #(.N_LINES(N), .CLK_DIV(CD), .SETTLE_PERIODS(SP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ddr_data(ddr_data), .pdm_clk(pdm_clk),
    .sdr_data_0(sdr_data_0), .sdr_data_1(sdr_data_1), .sdr_valid(sdr_valid),
    .sdr_ready(sdr_ready), .ovf_clr(ovf_clr), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_k counts clk cycles since capture was enabled; everything
  // else (phase, period number, settle end) is derived from it arithmetically.
  bit         m_active, m_stop, m_valid, m_ovf;
  int         m_k;
  logic [N-1:0] m_hold, m_d0, m_d1;

  function automatic int cur_phase();
    return m_k % PER;
  endfunction

  task automatic model_reset();
    m_active = 0; m_stop = 0; m_valid = 0; m_ovf = 0; m_k = 0;
    m_hold = '0; m_d0 = '0; m_d1 = '0;
  endtask

  task automatic model_edge(input bit en, input logic [N-1:0] d, input bit rdy, input bit clr);
    bit emit;
    bit set_ovf;
    emit = 0;
    set_ovf = 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_k = 0; m_stop = 0;
      end
    end else begin
      int ph;
      ph = m_k % PER;
      if (!en) m_stop = 1;
      if (ph == CD - 1) m_hold = d;
      if (ph == PER - 1 && (m_k / PER) >= SP) emit = 1;
      m_k++;
      if (ph == PER - 1 && m_stop) m_active = 0;
    end
    if (emit) begin
      set_ovf = m_valid && !rdy;
      m_d0 = m_hold;
      m_d1 = d;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (set_ovf)  m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic compare_all();
    check("pdm_clk",    pdm_clk,    m_active && (cur_phase() < CD));
    check("busy",       busy,       m_active);
    check("sdr_valid",  sdr_valid,  m_valid);
    check("overflow",   overflow,   m_ovf);
    check("sdr_data_0", sdr_data_0, m_d0);
    check("sdr_data_1", sdr_data_1, m_d1);
  endtask

  // Inputs change on the falling edge; the DUT is compared on the next falling edge.
  task automatic tick(input bit en, input logic [N-1:0] d, input bit rdy, input bit clr);
    enable = en; ddr_data = d; sdr_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    if (rst) model_edge(en, d, rdy, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_period(input logic [N-1:0] hi, input logic [N-1:0] lo, input bit rdy);
    for (int i = 0; i < PER; i++) tick(1, (i < CD) ? hi : lo, rdy, 0);
  endtask

  task automatic align_phase(input int ph);
    for (int i = 0; i < PER && cur_phase() != ph; i++) tick(1, N'($urandom), 1, 0);
  endtask

  initial begin
    int  n;
    bit  en_r, en, rdy;

    model_reset();
    rst = 0; enable = 1; ddr_data = '0; sdr_ready = 1; ovf_clr = 0;

    // Reset held with enable asserted: everything stays at zero.
    for (int i = 0; i < 3; i++) tick(1, N'($urandom), 1, 0);
    check("reset_busy", busy, 0);

    rst = 1;
    tick(1, N'($urandom), 1, 0);
    check("busy_after_release", busy, 1);

    // Settle: no pair for 4 periods, first pair lands at the end of period 5.
    n = 0;
    while (n < 40) begin
      tick(1, N'($urandom), 1, 0);
      n++;
      if (sdr_valid) break;
    end
    check("first_valid_edges", n, 20);

    // Basic pair capture with the consumer ready.
    align_phase(0);
    drive_period(8'hAA, 8'h55, 1);
    check("aa_valid", sdr_valid, 1);
    check("aa_d0", sdr_data_0, 8'hAA);
    check("aa_d1", sdr_data_1, 8'h55);
    tick(1, N'($urandom), 1, 0);
    check("aa_accepted", sdr_valid, 0);

    // Consumer stalls for two periods: second pair overwrites and flags overflow.
    align_phase(0);
    drive_period(8'hA5, 8'h5A, 0);
    drive_period(8'h3C, 8'hC3, 0);
    check("ovf_set", overflow, 1);
    check("ovf_d0", sdr_data_0, 8'h3C);
    check("ovf_d1", sdr_data_1, 8'hC3);
    check("ovf_valid_held", sdr_valid, 1);
    tick(1, N'($urandom), 0, 1);
    check("ovf_cleared", overflow, 0);
    tick(1, N'($urandom), 1, 0);
    check("ovf_accepted", sdr_valid, 0);

    // Enable dropped at cnt==1: period completes, final pair is emitted, then idle.
    align_phase(1);
    tick(0, N'($urandom), 1, 0);
    n = 0;
    while (busy && n < 10) begin
      tick(0, N'($urandom), 0, 0);
      n++;
    end
    check("stop_edges", n, 2);
    check("stop_pdm_low", pdm_clk, 0);
    check("stop_final_pair", sdr_valid, 1);

    // Random traffic: enable toggles (never first dropped on the last cycle of a
    // period), stretches of mostly-ready and mostly-stalled consumers.
    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 60 == 0) en_r = !en_r;
      en = en_r;
      if (m_active && !m_stop && cur_phase() == PER - 1) en = 1;
      rdy = (i < 1500) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      tick(en, N'($urandom), rdy, ($urandom % 16) == 0);
    end

    // Async reset in the middle of RUN with a pending pair.
    n = 0;
    while (n < 200 && !(m_active && !m_stop && m_valid && (m_k / PER) > SP)) begin
      tick(1, N'($urandom), 0, 0);
      n++;
    end
    check("pre_reset_valid", sdr_valid, 1);
    #2 rst = 0;
    #1;
    check("rst_pdm",   pdm_clk,   0);
    check("rst_valid", sdr_valid, 0);
    check("rst_ovf",   overflow,  0);
    check("rst_busy",  busy,      0);
    model_reset();
    @(negedge clk);
    tick(1, N'($urandom), 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
